// File: rtl/axis_gen_pkg.sv
// Shared types and helpers for the AXI-Stream frame generator.
// The data pattern lives here so a downstream checker can reuse it.
package axis_gen_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_LEN_W  = 8;
    localparam int DEF_CNT_W  = 8;
    localparam int DEF_GAP_W  = 4;

    // Pattern arithmetic is done at this width and truncated by the caller,
    // which keeps the helper usable for any DATA_W up to 32 bits.
    localparam int PATTERN_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } gen_state_t;

    // Beat n of a run carries seed + n; wrap-around comes from truncation.
    function automatic logic [PATTERN_W-1:0] gen_pattern(
        input logic [PATTERN_W-1:0] seed,
        input logic [PATTERN_W-1:0] index
    );
        return seed + index;
    endfunction

endpackage

// File: rtl/axis_frame_gen.sv
// AXI-Stream master that emits framed, deterministic test traffic.
// Every output is a register; tready only steers the next-state logic.
module axis_frame_gen
    import axis_gen_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int GAP_W  = DEF_GAP_W
) (
    input  logic              s_axis_aclk,
    input  logic              s_axis_aresetn,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [CNT_W-1:0]  cfg_frames,
    input  logic [GAP_W-1:0]  cfg_gap,
    input  logic [DATA_W-1:0] cfg_seed,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              done,
    output logic [31:0]       beats_sent
);

    gen_state_t        state;

    logic [LEN_W-1:0]  len_q;
    logic [CNT_W-1:0]  frames_q;
    logic [GAP_W-1:0]  gap_q;
    logic [DATA_W-1:0] seed_q;

    logic [LEN_W-1:0]  beat_idx;
    logic [CNT_W-1:0]  frame_idx;
    logic [GAP_W-1:0]  gap_cnt;
    logic [DATA_W-1:0] run_idx;
    logic              abort_pend;

    logic              hs;
    logic              last_frame;
    logic              stop_req;
    logic              start_ok;
    logic [LEN_W-1:0]  next_beat_idx;
    logic              next_is_last;
    logic              single_beat;
    logic [DATA_W-1:0] data_next;
    logic [DATA_W-1:0] data_resume;

    // Handshake, frame-boundary and next-beat decode shared by the FSM.
    always_comb begin
        hs            = m_axis_tvalid && m_axis_tready;
        last_frame    = (frame_idx == (frames_q - CNT_W'(1)));
        stop_req      = abort || abort_pend;
        start_ok      = (cfg_len != '0) && (cfg_frames != '0);
        next_beat_idx = beat_idx + LEN_W'(1);
        next_is_last  = (next_beat_idx == (len_q - LEN_W'(1)));
        single_beat   = (len_q == LEN_W'(1));
        data_next     = DATA_W'(gen_pattern(PATTERN_W'(seed_q),
                                            PATTERN_W'(run_idx) + PATTERN_W'(1)));
        data_resume   = DATA_W'(gen_pattern(PATTERN_W'(seed_q),
                                            PATTERN_W'(run_idx)));
    end

    // Run controller: latches the configuration, walks beats/frames/gaps
    // and drives the registered stream and status outputs.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state         <= IDLE;
            len_q         <= '0;
            frames_q      <= '0;
            gap_q         <= '0;
            seed_q        <= '0;
            beat_idx      <= '0;
            frame_idx     <= '0;
            gap_cnt       <= '0;
            run_idx       <= '0;
            abort_pend    <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            beats_sent    <= '0;
        end else begin
            done <= 1'b0;

            if (hs && (beats_sent != '1)) begin
                beats_sent <= beats_sent + 32'd1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            len_q         <= cfg_len;
                            frames_q      <= cfg_frames;
                            gap_q         <= cfg_gap;
                            seed_q        <= cfg_seed;
                            beat_idx      <= '0;
                            frame_idx     <= '0;
                            gap_cnt       <= '0;
                            run_idx       <= '0;
                            abort_pend    <= 1'b0;
                            beats_sent    <= '0;
                            busy          <= 1'b1;
                            m_axis_tvalid <= 1'b1;
                            m_axis_tdata  <= cfg_seed;
                            m_axis_tlast  <= (cfg_len == LEN_W'(1));
                            state         <= SEND;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end

                SEND: begin
                    if (abort) begin
                        abort_pend <= 1'b1;
                    end
                    if (hs) begin
                        run_idx <= run_idx + DATA_W'(1);
                        if (m_axis_tlast) begin
                            beat_idx <= '0;
                            if (last_frame || stop_req) begin
                                m_axis_tvalid <= 1'b0;
                                m_axis_tlast  <= 1'b0;
                                busy          <= 1'b0;
                                done          <= 1'b1;
                                state         <= FIN;
                            end else begin
                                frame_idx <= frame_idx + CNT_W'(1);
                                if (gap_q != '0) begin
                                    gap_cnt       <= gap_q;
                                    m_axis_tvalid <= 1'b0;
                                    m_axis_tlast  <= 1'b0;
                                    state         <= GAP;
                                end else begin
                                    m_axis_tdata <= data_next;
                                    m_axis_tlast <= single_beat;
                                end
                            end
                        end else begin
                            beat_idx     <= next_beat_idx;
                            m_axis_tdata <= data_next;
                            m_axis_tlast <= next_is_last;
                        end
                    end
                end

                GAP: begin
                    if (stop_req) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else if (gap_cnt == GAP_W'(1)) begin
                        gap_cnt       <= '0;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= data_resume;
                        m_axis_tlast  <= single_beat;
                        state         <= SEND;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end

                FIN: begin
                    abort_pend <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/axis_frame_gen.md
Name: axis_frame_gen

Overview:
- AXI-Stream transmitter (master) that generates framed test traffic into the slave side of the 16-bit stream FIFO path.
- Software/bench pulses `start` with a frame length, frame count, inter-frame gap and data seed. The block emits deterministic frames with `tlast` on each frame's final beat, fully honouring `m_axis_tready` backpressure.
- Sits upstream of the stream FIFO as its traffic source. The data pattern is a pure function of seed and beat index, so it pairs with a downstream checker.

Parameters:
- DATA_W, 16, width of m_axis_tdata.
- LEN_W, 8, width of frame length (beats per frame, 1..2^LEN_W-1).
- CNT_W, 8, width of frame count.
- GAP_W, 4, width of inter-frame idle-cycle count.

Ports:
- s_axis_aclk  in  1  single clock for the whole block.
- s_axis_aresetn  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  level; stop after the frame currently in flight.
- cfg_len  in  LEN_W  beats per frame, latched on accepted start.
- cfg_frames  in  CNT_W  number of frames, latched on accepted start.
- cfg_gap  in  GAP_W  idle cycles between frames (tvalid low), latched on accepted start.
- cfg_seed  in  DATA_W  data value of the first beat, latched on accepted start.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tdata  out  DATA_W  beat data.
- m_axis_tlast  out  1  final beat of frame.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the run ends.
- beats_sent  out  32  total handshakes since last accepted start; saturates at all-ones.

Behaviour:
Reset:
- s_axis_aresetn low clears immediately and asynchronously: tvalid=0, tlast=0, tdata=0, busy=0, done=0, beats_sent=0, all counters 0, state IDLE.
- Reset mid-frame truncates the frame with no tlast; this is accepted.

Handshake:
- Beat transfers when tvalid&&tready.
- Once tvalid=1 it stays 1 until the handshake completes.
- tdata/tlast are held constant while tvalid&&!tready.
- All outputs come from registers; no combinational path from tready to any output.

Data and arithmetic:
- tdata of the n-th beat of the run (n from 0, counted across frames) = cfg_seed + n, modulo 2^DATA_W (wraps silently).
- tlast=1 exactly on beat index cfg_len-1 of each frame.

States:
- IDLE: busy=0. On start with cfg_len!=0 and cfg_frames!=0: latch the cfg_* inputs, clear beats_sent, go to SEND. tvalid=1 with the first beat on the next cycle (1-cycle latency).
- IDLE, degenerate start: start with cfg_len==0 or cfg_frames==0 gives done=1 on the next cycle, zero beats, and the block stays in IDLE.
- SEND: present beats. On handshake of a non-last beat, load the next beat in the same cycle, so a continuously ready sink sees one beat per cycle.
- SEND, frame end: on handshake of a last beat, if the frame just finished was the final one or abort=1, go to FIN. Otherwise go to GAP if cfg_gap!=0, or stay in SEND with the next frame's first beat valid next cycle (back-to-back frames) if cfg_gap==0.
- GAP: tvalid=0 for exactly cfg_gap cycles, then SEND.
- GAP, abort: abort=1 in GAP goes straight to FIN.
- FIN: tvalid=0, done=1 for one cycle, busy=0 from the same cycle, then IDLE.

Boundaries:
- start while busy is ignored.
- cfg_* changes after latch have no effect.
- abort never drops or alters a pending beat. It only acts at frame boundaries or in GAP.
- abort together with the last handshake of the final frame ends identically to a normal finish: one done pulse.
- cfg_len=1 gives tlast on every beat.
- Frame and beat counters never wrap inside a run.

Decomposition:
- Package axis_gen_pkg: state enum (IDLE, SEND, GAP, FIN), a pattern function (seed, index) -> data, and default width constants.
- No sub-module required. The output register stage is folded into the FSM.

Test Plan:
- len=4, frames=2, gap=0, seed=16'h0010, tready=1 -> 8 consecutive beats, data 0x0010..0x0017, tlast on beats 3 and 7, done one cycle after the last beat, beats_sent=8.
- len=3, frames=2, gap=2, tready toggling 1,0,0,1 repeatedly -> data/tlast stable during stalls, exactly 2 tvalid-low cycles between frames, 6 beats 0x0000..0x0005.
- seed=16'hFFFE, len=4, frames=1 -> data FFFE, FFFF, 0000, 0001 with tlast on 0001.
- len=5, frames=10, abort pulsed during beat 2 of frame 0 with tready=0 at that time -> frame 0 completes all 5 beats with tlast, then done, beats_sent=5.
- Degenerate and busy starts: start with cfg_len=0 -> done next cycle, tvalid never high; start re-pulsed while busy -> ignored, run unchanged.
- Assert s_axis_aresetn low mid-frame while tvalid=1 -> tvalid, busy and beats_sent drop to 0 without waiting for a clock edge; after release, a new start runs normally from seed.
